// File: rtl/manchester_decoder.sv
// Manchester (IEEE 802.3) frame decoder: start bit '1', 8 data bits LSB first.
// Ports: clk, rst_n (async low), rx (line) -> data, valid, err, busy.
module manchester_decoder #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       err,
  output logic       busy
);

  localparam int CW = $clog2(OVERSAMPLE) + 1;
  localparam logic [CW-1:0] SAMP = CW'(3 * OVERSAMPLE / 4 - 1);
  localparam logic [CW-1:0] TOUT = CW'(5 * OVERSAMPLE / 4);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SAMPLE,
    WAIT_EDGE
  } state_t;

  state_t state;
  state_t state_n;

  logic rx_m;
  logic rx_s;
  logic rx_d;
  logic rise;
  logic chg;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          h;
  logic          h_n;
  logic [2:0]    idx;
  logic [2:0]    idx_n;
  logic [7:0]    sr;
  logic [7:0]    sr_n;
  logic          done;
  logic          done_n;
  logic          fail;
  logic          fail_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b0;
      rx_s <= 1'b0;
      rx_d <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign rise = rx_s & ~rx_d;
  assign chg  = rx_s ^ rx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      h     <= 1'b0;
      idx   <= '0;
      sr    <= '0;
      done  <= 1'b0;
      fail  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      h     <= h_n;
      idx   <= idx_n;
      sr    <= sr_n;
      done  <= done_n;
      fail  <= fail_n;
    end
  end

  // h is the first-half level of the bit; the mid-bit edge must move
  // the line away from it, otherwise an extra transition slipped in.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    h_n     = h;
    idx_n   = idx;
    sr_n    = sr;
    done_n  = 1'b0;
    fail_n  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (rise) begin
          idx_n   = '0;
          state_n = WAIT_SAMPLE;
        end
      end
      WAIT_SAMPLE: begin
        cnt_n = cnt + CW'(1);
        if (cnt == SAMP) begin
          h_n     = rx_s;
          state_n = WAIT_EDGE;
        end
      end
      WAIT_EDGE: begin
        cnt_n = cnt + CW'(1);
        if (chg) begin
          cnt_n = '0;
          if (rx_s == h) begin
            fail_n  = 1'b1;
            state_n = IDLE;
          end else begin
            sr_n[idx] = ~h;
            idx_n     = idx + 3'd1;
            if (idx == 3'd7) begin
              done_n  = 1'b1;
              state_n = IDLE;
            end else begin
              state_n = WAIT_SAMPLE;
            end
          end
        end else if (cnt == TOUT) begin
          cnt_n   = '0;
          fail_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // Output stage: one register after the FSM decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= 8'h00;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      valid <= done;
      err   <= fail;
      if (done) begin
        data <= sr;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_manchester_decoder.sv
// Scoreboard bench for manchester_decoder: directed frames, timeout,
// reset abort, jitter and idle glitch.
module tb_manchester_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       err;
  logic       busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  typedef int off_t[9];

  exp_t vq[$];
  int   eq[$];

  off_t nom = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
  off_t jit = '{3, 0, -3, 0, 3, 1, -2, 1, -1};

  manchester_decoder #(.OVERSAMPLE(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rx   (rx),
    .data (data),
    .valid(valid),
    .err  (err),
    .busy (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask

  logic pv = 1'b0;
  logic pe = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && err) chk("valid_and_err", 1, 0);
      if (valid && pv) chk("valid_2cyc", 1, 0);
      if (err && pe) chk("err_2cyc", 1, 0);
      if (valid) begin
        if (vq.size() == 0) begin
          chk("valid_unexpected", {24'h0, data}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = vq.pop_front();
          chk("data", {24'h0, data}, {24'h0, e.d});
          chk("valid_cycle", cyc, e.c);
        end
      end
      if (err) begin
        if (eq.size() == 0) begin
          chk("err_unexpected", cyc, 32'hFFFF_FFFF);
        end else begin
          int c;
          c = eq.pop_front();
          chk("err_cycle", cyc, c);
        end
      end
    end
    pv = valid;
    pe = err;
  end

  task automatic idle(input int n);
    rx = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // cutk >= 0: stop after the mid-bit edge of bit cutk (0 = start bit);
  // with do_rst the frame is aborted by reset, otherwise rx is held.
  task automatic send(input logic [7:0] b, input off_t off,
                      input int cutk, input bit do_rst);
    int m[9];
    int bnd[10];
    logic [8:0] bits;
    int k;
    int cmid;
    bits = {b, 1'b1};
    cmid = 0;
    for (int i = 0; i < 9; i++) m[i] = 8 + 16 * i + off[i];
    bnd[0] = 0;
    for (int i = 1; i < 9; i++) bnd[i] = (m[i-1] + m[i]) / 2;
    bnd[9] = m[8] + 8;
    for (int t = 0; t < bnd[9]; t++) begin
      if (cutk >= 0 && t == m[cutk] + 1) begin
        if (do_rst) begin
          rst_n = 1'b0;
          rx = 1'b0;
          repeat (3) @(negedge clk);
          chk("rst_data", {24'h0, data}, 0);
          chk("rst_busy", busy, 0);
          chk("rst_valid", valid, 0);
          rst_n = 1'b1;
        end else begin
          eq.push_back(cmid + 25);
        end
        return;
      end
      k = 0;
      for (int i = 0; i < 9; i++) if (t >= bnd[i]) k = i;
      rx = (t < m[k]) ? ~bits[k] : bits[k];
      if (t == m[8]) vq.push_back('{b, cyc + 4});
      if (cutk >= 0 && t == m[cutk]) cmid = cyc;
      @(negedge clk);
    end
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_data", {24'h0, data}, 0);
    chk("reset_valid", valid, 0);
    chk("reset_err", err, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;
    idle(5);

    send(8'hA5, nom, -1, 1'b0);
    idle(40);
    chk("a5_busy_after", busy, 0);
    chk("a5_data_hold", {24'h0, data}, 32'hA5);

    send(8'h00, nom, -1, 1'b0);
    idle(16);
    send(8'hFF, nom, -1, 1'b0);
    idle(40);

    send(8'hA5, nom, 4, 1'b0);
    repeat (40) @(negedge clk);
    chk("tmo_data_kept", {24'h0, data}, 32'hFF);
    chk("tmo_busy", busy, 0);
    idle(5);

    send(8'h3C, nom, 6, 1'b1);
    idle(5);
    send(8'h81, nom, -1, 1'b0);
    idle(40);

    send(8'h5A, jit, -1, 1'b0);
    idle(40);
    chk("jit_data", {24'h0, data}, 32'h5A);

    rx = 1'b1;
    c = cyc;
    eq.push_back(c + 25);
    @(negedge clk);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    chk("glitch_busy", busy, 1);
    repeat (40) @(negedge clk);
    chk("glitch_idle", busy, 0);
    chk("glitch_data_kept", {24'h0, data}, 32'h5A);

    chk("valid_left", vq.size(), 0);
    chk("err_left", eq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
